// File: rtl/ram_simple_dual_port_if.sv
// rtl/ram_simple_dual_port_if.sv - write/read port bundle for ram_simple_dual_port
interface ram_simple_dual_port_if #(
    parameter int WIDTH         = 32,
    parameter int ADDRESS_WIDTH = 4,
    parameter int BYTE_WIDTH    = 8
);
    logic                        ready;
    logic                        write_enable;
    logic [ADDRESS_WIDTH-1:0]    write_address;
    logic [WIDTH/BYTE_WIDTH-1:0] write_byte_enable;
    logic [WIDTH-1:0]            write_data;
    logic                        read_enable;
    logic [ADDRESS_WIDTH-1:0]    read_address;
    logic [WIDTH-1:0]            read_data;
    logic                        read_valid;

    modport master (
        input  ready, read_data, read_valid,
        output write_enable, write_address, write_byte_enable, write_data,
        output read_enable, read_address
    );

    modport slave (
        output ready, read_data, read_valid,
        input  write_enable, write_address, write_byte_enable, write_data,
        input  read_enable, read_address
    );
endinterface

// File: rtl/ram_simple_dual_port.sv
// rtl/ram_simple_dual_port.sv - simple dual-port RAM with byte enables, init sweep and 1/2-cycle read
module ram_simple_dual_port #(
    parameter int               WIDTH         = 32,
    parameter int               DEPTH         = 16,
    parameter int               ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int               BYTE_WIDTH    = 8,
    parameter int               READ_LATENCY  = 1,
    parameter int               WRITE_FIRST   = 0,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
    input logic                   clock,
    input logic                   reset,
    ram_simple_dual_port_if.slave bus
);
    localparam int LANES = WIDTH / BYTE_WIDTH;

    localparam logic [0:0] STATE_INIT  = 1'b0;
    localparam logic [0:0] STATE_READY = 1'b1;

    localparam logic [ADDRESS_WIDTH:0]   DEPTH_LIMIT  = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]         memory [DEPTH];
    logic [0:0]               state;
    logic [ADDRESS_WIDTH-1:0] init_count;
    logic                     ready;
    logic                     write_hit;
    logic                     read_hit;
    logic                     read_in_range;
    logic [WIDTH-1:0]         read_word;
    logic                     stage1_valid;
    logic [WIDTH-1:0]         stage1_data;

    assign ready         = (state == STATE_READY);
    assign bus.ready     = ready;
    assign write_hit     = ready && bus.write_enable && ({1'b0, bus.write_address} < DEPTH_LIMIT);
    assign read_hit      = ready && bus.read_enable;
    assign read_in_range = ({1'b0, bus.read_address} < DEPTH_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= STATE_INIT;
            init_count <= '0;
        end else if (state == STATE_INIT) begin
            if (init_count == LAST_ADDRESS) begin
                state <= STATE_READY;
            end else begin
                init_count <= init_count + 1'b1;
            end
        end
    end

    // Storage has no reset so it can map onto block RAM; the init sweep clears it instead.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == STATE_INIT) begin
                memory[init_count] <= INIT_VALUE;
            end else if (write_hit) begin
                for (int b = 0; b < LANES; b++) begin
                    if (bus.write_byte_enable[b]) begin
                        memory[bus.write_address][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                            bus.write_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // Out-of-range reads return zero; write-first forwards the enabled lanes of a colliding write.
    always_comb begin
        read_word = '0;
        if (read_in_range) begin
            read_word = memory[bus.read_address];
        end
        if ((WRITE_FIRST != 0) && write_hit && (bus.write_address == bus.read_address)) begin
            for (int b = 0; b < LANES; b++) begin
                if (bus.write_byte_enable[b]) begin
                    read_word[b*BYTE_WIDTH +: BYTE_WIDTH] = bus.write_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stage1_valid <= 1'b0;
            stage1_data  <= '0;
        end else begin
            stage1_valid <= read_hit;
            if (read_hit) begin
                stage1_data <= read_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_output_register
            logic             stage2_valid;
            logic [WIDTH-1:0] stage2_data;

            always_ff @(posedge clock) begin
                if (reset) begin
                    stage2_valid <= 1'b0;
                    stage2_data  <= '0;
                end else begin
                    stage2_valid <= stage1_valid;
                    if (stage1_valid) begin
                        stage2_data <= stage1_data;
                    end
                end
            end

            assign bus.read_valid = stage2_valid;
            assign bus.read_data  = stage2_data;
        end else begin : g_direct_output
            assign bus.read_valid = stage1_valid;
            assign bus.read_data  = stage1_data;
        end
    endgenerate
endmodule
